// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - received-byte strobe bundle between the UART receiver and the RX FIFO
interface uart_rx_byte_if;
   logic [7:0] rdata;
   logic       rvalid;
   logic       ferr;
   logic       perr;

   modport master (output rdata, rvalid, ferr, perr);
   modport slave  (input  rdata, rvalid, ferr, perr);
endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 serial receiver emitting one-cycle byte/error strobes
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_byte #(
   parameter int CLK_PER_BIT = 868
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           rxd,
   output logic           busy,
   uart_rx_byte_if.master rx
);
   localparam int CW = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLK_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t        r_state, w_state;
   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [2:0]    r_idx, w_idx;
   logic [7:0]    r_sh, w_sh;
   logic [7:0]    r_rdata, w_rdata;
   logic          r_rvalid, w_rvalid;
   logic          r_ferr, w_ferr;
   logic          w_rxd_s;
   logic [CW-1:0] w_cnt_inc;
`ifdef UART_RX_PARITY_EN
   logic          r_perr, w_perr;
   logic          r_par_bad, w_par_bad;
`endif

   assign w_rxd_s   = r_sync[1];
   assign w_cnt_inc = r_cnt + CW'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync    <= 2'b11;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_sh      <= '0;
         r_rdata   <= '0;
         r_rvalid  <= 1'b0;
         r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr    <= 1'b0;
         r_par_bad <= 1'b0;
`endif
      end else begin
         r_sync    <= {r_sync[0], rxd};
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_idx     <= w_idx;
         r_sh      <= w_sh;
         r_rdata   <= w_rdata;
         r_rvalid  <= w_rvalid;
         r_ferr    <= w_ferr;
`ifdef UART_RX_PARITY_EN
         r_perr    <= w_perr;
         r_par_bad <= w_par_bad;
`endif
      end
   end

   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_idx    = r_idx;
      w_sh     = r_sh;
      w_rdata  = r_rdata;
      w_rvalid = 1'b0;
      w_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_perr    = 1'b0;
      w_par_bad = r_par_bad;
`endif
      case (r_state)
         S_IDLE: begin
            if (!w_rxd_s) begin
               w_state = S_START;
               w_cnt   = '0;
            end
         end
         // Mid-start-bit recheck rejects short glitches on the idle line
         S_START: begin
            if (r_cnt == HALF_M1) begin
               w_cnt = '0;
               w_idx = '0;
               w_state = w_rxd_s ? S_IDLE : S_DATA;
            end else begin
               w_cnt = w_cnt_inc;
            end
         end
         S_DATA: begin
            if (r_cnt == BIT_M1) begin
               w_sh  = {w_rxd_s, r_sh[7:1]};
               w_cnt = '0;
               if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state = S_PARITY;
`else
                  w_state = S_STOP;
`endif
               end else begin
                  w_idx = r_idx + 3'd1;
               end
            end else begin
               w_cnt = w_cnt_inc;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (r_cnt == BIT_M1) begin
               w_par_bad = ^{r_sh, w_rxd_s};
               w_cnt     = '0;
               w_state   = S_STOP;
            end else begin
               w_cnt = w_cnt_inc;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt == BIT_M1) begin
               w_cnt = '0;
               if (w_rxd_s) begin
                  w_state = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (r_par_bad) begin
                     w_perr = 1'b1;
                  end else begin
                     w_rdata  = r_sh;
                     w_rvalid = 1'b1;
                  end
`else
                  w_rdata  = r_sh;
                  w_rvalid = 1'b1;
`endif
               end else begin
                  w_ferr  = 1'b1;
                  w_state = S_BREAK;
               end
            end else begin
               w_cnt = w_cnt_inc;
            end
         end
         // A held-low line must return high before a new start bit is accepted
         S_BREAK: begin
            if (w_rxd_s) begin
               w_state = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign busy      = (r_state != S_IDLE);
   assign rx.rdata  = r_rdata;
   assign rx.rvalid = r_rvalid;
   assign rx.ferr   = r_ferr;
`ifdef UART_RX_PARITY_EN
   assign rx.perr   = r_perr;
`else
   assign rx.perr   = 1'b0;
`endif
endmodule
